// File: rtl/lane_sched_pkg.sv
// lane_sched_pkg: shared states, requester indices and trigger codes for the lane TX scheduler
package lane_sched_pkg;
  typedef enum logic [2:0] {S_IDLE, S_HS, S_LPDT, S_TRIG, S_ULPS, S_WAIT_STOP, S_GAP} state_t;
  localparam int REQ_HS   = 0;
  localparam int REQ_LPDT = 1;
  localparam int REQ_TRIG = 2;
  localparam int REQ_ULPS = 3;
  localparam logic RR_LPDT = 1'b0;
  localparam logic RR_HS   = 1'b1;
  localparam logic [3:0] TRIG_RESET = 4'b0001;
  localparam logic [3:0] TRIG_3     = 4'b0010;
  localparam logic [3:0] TRIG_ACK   = 4'b0100;
  localparam logic [3:0] TRIG_4     = 4'b1000;
endpackage

// File: rtl/lp_cycle_timer.sv
// lp_cycle_timer: up-counter whose terminal hit fires on the limit-th enabled cycle and self-clears
module lp_cycle_timer #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);
  logic [CNT_W-1:0] cnt;
  assign hit = en && cnt == limit - 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr || hit) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/lane_tx_scheduler.sv
// lane_tx_scheduler: arbitrates HS/LPDT/trigger/ULPS requesters and sequences the lane PPI request pins
module lane_tx_scheduler import lane_sched_pkg::*; #(
  parameter int MIN_GAP_CYC = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       stop_state,
  input  logic       ulps_active_n,
  input  logic       tx_rd_esc,
  input  logic       hs_req,
  input  logic       hs_end,
  output logic       hs_gnt,
  input  logic       lpdt_req,
  input  logic       lpdt_valid,
  input  logic       lpdt_last,
  input  logic [7:0] lpdt_data,
  output logic       lpdt_ready,
  input  logic       trig_req,
  input  logic [3:0] trig_code,
  output logic       trig_ack,
  input  logic       ulps_req,
  input  logic       ulps_exit_req,
  output logic       ulps_ack,
  output logic       tx_rq_hs,
  output logic       tx_rq_esc,
  output logic       tx_lpdt_esc,
  output logic       tx_ulps_esc,
  output logic       tx_ulps_exit,
  output logic       tx_valid_esc,
  output logic [3:0] tx_trigger_esc,
  output logic [7:0] tx_data_esc,
  output logic       busy,
  output logic       err_timeout,
  output logic       err_cmd
);
  state_t state;
  logic rr_last, trig_pend, active, gap, in_lpdt, hit, timeout, pick_hs;
  assign active = state inside {S_HS, S_LPDT, S_TRIG, S_ULPS};
  assign gap = state == S_GAP;
  assign in_lpdt = state == S_LPDT;
  assign timeout = active && hit;
  assign pick_hs = hs_req && (!lpdt_req || rr_last != RR_HS);
  assign busy = state != S_IDLE;
  assign hs_gnt = state == S_HS && !stop_state;
  assign ulps_ack = state == S_ULPS && !ulps_active_n;
  assign lpdt_ready = in_lpdt && tx_rd_esc;
  assign tx_valid_esc = in_lpdt && lpdt_valid;
  assign tx_data_esc = in_lpdt ? lpdt_data : 8'h00;
  // One counter serves both the Stop-exit timeout and the inter-transaction gap
  lp_cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (!stop_state || !(active || gap)),
    .en   (stop_state && (gap || (active && !ulps_ack))),
    .limit(gap ? CNT_W'(MIN_GAP_CYC) : CNT_W'(TIMEOUT_CYC)),
    .hit  (hit)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      rr_last <= RR_LPDT;
      trig_pend <= 1'b0;
      {tx_rq_hs, tx_rq_esc, tx_lpdt_esc, tx_ulps_esc, tx_ulps_exit, tx_trigger_esc} <= '0;
      {trig_ack, err_cmd, err_timeout} <= '0;
    end else begin
      {trig_ack, err_cmd, err_timeout} <= '0;
      if (timeout) begin
        {tx_rq_hs, tx_rq_esc, tx_lpdt_esc, tx_ulps_esc, tx_ulps_exit, tx_trigger_esc} <= '0;
        err_timeout <= 1'b1;
        state <= S_GAP;
      end else
        case (state)
          S_IDLE:
            if (enable && stop_state) begin
              if (trig_req) begin
                if ($onehot(trig_code)) begin
                  state <= S_TRIG;
                  tx_rq_esc <= 1'b1;
                  tx_trigger_esc <= trig_code;
                end else {trig_ack, err_cmd} <= 2'b11;
              end else if (ulps_req) begin
                state <= S_ULPS;
                {tx_rq_esc, tx_ulps_esc} <= 2'b11;
              end else if (pick_hs) begin
                state <= S_HS;
                tx_rq_hs <= 1'b1;
              end else if (lpdt_req) begin
                state <= S_LPDT;
                {tx_rq_esc, tx_lpdt_esc} <= 2'b11;
              end
            end
          S_HS:
            if (hs_end) begin
              tx_rq_hs <= 1'b0;
              rr_last <= RR_HS;
              state <= S_WAIT_STOP;
            end
          S_LPDT:
            if (lpdt_valid && tx_rd_esc && lpdt_last) begin
              {tx_rq_esc, tx_lpdt_esc} <= 2'b00;
              rr_last <= RR_LPDT;
              state <= S_WAIT_STOP;
            end
          S_TRIG:
            if (!stop_state) begin
              tx_rq_esc <= 1'b0;
              tx_trigger_esc <= 4'b0000;
              trig_pend <= 1'b1;
              state <= S_WAIT_STOP;
            end
          S_ULPS:
            if (ulps_ack && ulps_exit_req) begin
              {tx_rq_esc, tx_ulps_esc, tx_ulps_exit} <= 3'b001;
              state <= S_WAIT_STOP;
            end
          S_WAIT_STOP:
            if (stop_state) begin
              tx_ulps_exit <= 1'b0;
              trig_ack <= trig_pend;
              trig_pend <= 1'b0;
              state <= S_GAP;
            end
          S_GAP: if (hit) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_lane_tx_scheduler.sv
// tb_lane_tx_scheduler: directed self-checking bench for lane_tx_scheduler
module tb_lane_tx_scheduler;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b1, stop_state = 1'b1, ulps_active_n = 1'b1, tx_rd_esc = 1'b0;
  logic hs_req = 1'b0, hs_end = 1'b0, lpdt_req = 1'b0, lpdt_valid = 1'b0, lpdt_last = 1'b0;
  logic [7:0] lpdt_data = 8'h00;
  logic trig_req = 1'b0, ulps_req = 1'b0, ulps_exit_req = 1'b0;
  logic [3:0] trig_code = 4'b0000;
  logic hs_gnt, lpdt_ready, trig_ack, ulps_ack, tx_rq_hs, tx_rq_esc, tx_lpdt_esc, tx_ulps_esc;
  logic tx_ulps_exit, tx_valid_esc, busy, err_timeout, err_cmd;
  logic [3:0] tx_trigger_esc;
  logic [7:0] tx_data_esc;
  logic [24:0] outs;
  int checks = 0, errors = 0;
  assign outs = {busy, hs_gnt, tx_rq_hs, tx_rq_esc, tx_lpdt_esc, tx_ulps_esc, tx_ulps_exit, tx_valid_esc,
                 lpdt_ready, trig_ack, ulps_ack, err_timeout, err_cmd, tx_trigger_esc, tx_data_esc};
  always #5 clk = ~clk;
  lane_tx_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .stop_state(stop_state), .ulps_active_n(ulps_active_n),
    .tx_rd_esc(tx_rd_esc), .hs_req(hs_req), .hs_end(hs_end), .hs_gnt(hs_gnt), .lpdt_req(lpdt_req),
    .lpdt_valid(lpdt_valid), .lpdt_last(lpdt_last), .lpdt_data(lpdt_data), .lpdt_ready(lpdt_ready),
    .trig_req(trig_req), .trig_code(trig_code), .trig_ack(trig_ack), .ulps_req(ulps_req),
    .ulps_exit_req(ulps_exit_req), .ulps_ack(ulps_ack), .tx_rq_hs(tx_rq_hs), .tx_rq_esc(tx_rq_esc),
    .tx_lpdt_esc(tx_lpdt_esc), .tx_ulps_esc(tx_ulps_esc), .tx_ulps_exit(tx_ulps_exit),
    .tx_valid_esc(tx_valid_esc), .tx_trigger_esc(tx_trigger_esc), .tx_data_esc(tx_data_esc),
    .busy(busy), .err_timeout(err_timeout), .err_cmd(err_cmd)
  );
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] bytes [3];
    int hs, n;
    bytes[0] = 8'hA5;
    bytes[1] = 8'h5A;
    bytes[2] = 8'hFF;
    cyc(2);
    chk("reset_outs", 32'(outs), 32'h0);
    rst = 1'b0;
    cyc(1);
    chk("idle_outs", 32'(outs), 32'h0);
    hs_req = 1'b1;
    lpdt_req = 1'b1;
    cyc(1);
    chk("rr_hs_first", tx_rq_hs, 1'b1);
    chk("rr_no_lpdt", tx_rq_esc, 1'b0);
    chk("hs_gnt_in_stop", hs_gnt, 1'b0);
    stop_state = 1'b0;
    #1;
    chk("hs_gnt_out_stop", hs_gnt, 1'b1);
    cyc(3);
    hs_end = 1'b1;
    hs_req = 1'b0;
    cyc(1);
    hs_end = 1'b0;
    chk("hs_end_drop", {busy, tx_rq_hs}, 2'b10);
    cyc(2);
    stop_state = 1'b1;
    cyc(1);
    cyc(7);
    chk("gap_busy", {busy, tx_rq_esc}, 2'b10);
    cyc(1);
    chk("gap_done_idle", {busy, tx_rq_esc}, 2'b00);
    cyc(1);
    chk("lpdt_granted", {tx_rq_esc, tx_lpdt_esc}, 2'b11);
    hs = 0;
    stop_state = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n = hs < 3 ? hs : 2;
      lpdt_valid = 1'b1;
      lpdt_data = bytes[n];
      lpdt_last = n == 2;
      tx_rd_esc = k % 4 == 3;
      #1;
      if (lpdt_ready && lpdt_valid) begin
        chk($sformatf("lpdt_byte%0d", hs), {tx_valid_esc, tx_data_esc}, {1'b1, bytes[n]});
        hs++;
      end
      cyc(1);
    end
    chk("lpdt_handshakes", hs, 3);
    chk("lpdt_rq_drop", {tx_rq_esc, tx_lpdt_esc, busy}, 3'b001);
    {lpdt_valid, lpdt_last, lpdt_req, tx_rd_esc} = '0;
    stop_state = 1'b1;
    cyc(9);
    chk("lpdt_gap_idle", busy, 1'b0);
    trig_req = 1'b1;
    trig_code = 4'b0100;
    cyc(1);
    chk("trig_rq", {tx_rq_esc, tx_trigger_esc}, 5'b1_0100);
    cyc(2);
    chk("trig_hold", {tx_rq_esc, tx_trigger_esc, trig_ack}, 6'b1_0100_0);
    stop_state = 1'b0;
    cyc(1);
    chk("trig_drop", {tx_rq_esc, tx_trigger_esc, trig_ack}, 6'b0);
    cyc(2);
    stop_state = 1'b1;
    cyc(1);
    chk("trig_ack", trig_ack, 1'b1);
    trig_req = 1'b0;
    cyc(1);
    chk("trig_ack_pulse", trig_ack, 1'b0);
    cyc(7);
    chk("trig_gap_idle", busy, 1'b0);
    trig_req = 1'b1;
    trig_code = 4'b0110;
    cyc(1);
    trig_req = 1'b0;
    chk("bad_code", {trig_ack, err_cmd, tx_rq_esc, busy}, 4'b1100);
    cyc(1);
    chk("bad_code_pulse", {trig_ack, err_cmd, busy}, 3'b000);
    ulps_exit_req = 1'b1;
    cyc(2);
    chk("exit_ignored_idle", {busy, tx_ulps_exit}, 2'b00);
    ulps_exit_req = 1'b0;
    ulps_req = 1'b1;
    cyc(1);
    ulps_req = 1'b0;
    chk("ulps_rq", {tx_rq_esc, tx_ulps_esc, ulps_ack}, 3'b110);
    stop_state = 1'b0;
    ulps_exit_req = 1'b1;
    cyc(1);
    chk("exit_before_ack", {tx_ulps_esc, tx_ulps_exit}, 2'b10);
    ulps_active_n = 1'b0;
    #1;
    chk("ulps_ack", ulps_ack, 1'b1);
    cyc(1);
    ulps_exit_req = 1'b0;
    chk("ulps_exit", {tx_rq_esc, tx_ulps_esc, tx_ulps_exit}, 3'b001);
    ulps_active_n = 1'b1;
    cyc(3);
    chk("ulps_exit_hold", tx_ulps_exit, 1'b1);
    stop_state = 1'b1;
    cyc(1);
    chk("ulps_exit_clear", {tx_ulps_exit, busy}, 2'b01);
    cyc(3);
    stop_state = 1'b0;
    cyc(1);
    stop_state = 1'b1;
    cyc(7);
    chk("gap_restart_busy", busy, 1'b1);
    cyc(1);
    chk("gap_restart_idle", busy, 1'b0);
    hs_req = 1'b1;
    cyc(1);
    hs_req = 1'b0;
    chk("to_hs_rq", tx_rq_hs, 1'b1);
    n = 0;
    for (int i = 0; i < 1100 && !err_timeout; i++) begin
      cyc(1);
      n++;
    end
    chk("timeout_cycles", n, 1024);
    chk("timeout_state", {err_timeout, tx_rq_hs, busy}, 3'b101);
    cyc(1);
    chk("timeout_pulse", err_timeout, 1'b0);
    cyc(7);
    chk("timeout_idle", busy, 1'b0);
    enable = 1'b0;
    hs_req = 1'b1;
    lpdt_req = 1'b1;
    cyc(5);
    chk("enable_block", {busy, tx_rq_hs, tx_rq_esc}, 3'b000);
    enable = 1'b1;
    cyc(1);
    chk("rr_after_lpdt", {tx_rq_hs, tx_rq_esc}, 2'b10);
    hs_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_hs", 32'(outs), 32'h0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("lpdt_alone", {tx_rq_esc, tx_lpdt_esc}, 2'b11);
    stop_state = 1'b0;
    lpdt_valid = 1'b1;
    tx_rd_esc = 1'b1;
    #1;
    chk("lpdt_ready", lpdt_ready, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_lpdt", 32'(outs), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
